// File: rtl/gif_frame_player.sv
// Playback sequencer: streams each stored frame from the GIF ROM into the back framebuffer bank,
// requests a bank swap, then holds the frame for FRAME_TICKS clocks before loading the next one.
module gif_frame_player #(
  parameter int unsigned FRAME_W     = 32,
  parameter int unsigned FRAME_H     = 32,
  parameter int unsigned NUM_FRAMES  = 60,
  parameter int unsigned FRAME_TICKS = 5_000_000,
  parameter int unsigned PIX_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [15:0]      rom_addr,
  input  logic [7:0]       rom_data,
  output logic             fb_we,
  output logic [PIX_W-1:0] fb_addr,
  output logic [2:0]       fb_data,
  output logic             fb_bank,
  output logic             swap_req,
  input  logic             swap_ack,
  output logic [5:0]       frame_idx,
  output logic             busy
);

  localparam int unsigned NPix  = FRAME_W * FRAME_H;
  localparam int unsigned HoldW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [PIX_W-1:0] LastPix   = PIX_W'(NPix - 1);
  localparam logic [15:0]      FrameSize = 16'(NPix);
  localparam logic [5:0]       LastFrame = 6'(NUM_FRAMES - 1);
  localparam logic [HoldW-1:0] HoldLoad  = HoldW'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle, StCopy, StFlush0, StFlush1, StSwapWait, StHold
  } state_e;

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [15:0]      frame_base_q, frame_base_d;
  logic [5:0]       frame_idx_q, frame_idx_d;
  logic [15:0]      rom_addr_q, rom_addr_d;
  logic             fb_bank_q, fb_bank_d;

  logic             s1_valid_q;
  logic [PIX_W-1:0] s1_pix_q;
  logic             fb_we_q;
  logic [PIX_W-1:0] fb_addr_q;
  logic [2:0]       fb_data_q;
  logic             swap_req_q;
  logic             busy_q;

  // Only the RGB bits of each ROM byte carry pixel data.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[7:3];

  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    hold_d       = hold_q;
    frame_base_d = frame_base_q;
    frame_idx_d  = frame_idx_q;
    rom_addr_d   = rom_addr_q;
    fb_bank_d    = fb_bank_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StCopy;
          pix_d      = '0;
          rom_addr_d = frame_base_q;
        end
      end
      StCopy: begin
        if (pix_q == LastPix) begin
          state_d = StFlush0;
        end else begin
          pix_d      = pix_q + PIX_W'(1);
          rom_addr_d = rom_addr_q + 16'd1;
        end
      end
      StFlush0: state_d = StFlush1;
      StFlush1: state_d = StSwapWait;
      StSwapWait: begin
        if (swap_ack) begin
          state_d   = StHold;
          fb_bank_d = ~fb_bank_q;
          hold_d    = HoldLoad;
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          if (frame_idx_q == LastFrame) begin
            frame_idx_d  = '0;
            frame_base_d = '0;
          end else begin
            frame_idx_d  = frame_idx_q + 6'd1;
            frame_base_d = frame_base_q + FrameSize;
          end
          if (enable) begin
            state_d    = StCopy;
            pix_d      = '0;
            rom_addr_d = frame_base_d;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pix_q        <= '0;
      hold_q       <= '0;
      frame_base_q <= '0;
      frame_idx_q  <= '0;
      rom_addr_q   <= '0;
      fb_bank_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      swap_req_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      hold_q       <= hold_d;
      frame_base_q <= frame_base_d;
      frame_idx_q  <= frame_idx_d;
      rom_addr_q   <= rom_addr_d;
      fb_bank_q    <= fb_bank_d;
      // Stage 1 tags the address presented this cycle; stage 2 pairs it with the ROM reply.
      s1_valid_q   <= (state_q == StCopy);
      s1_pix_q     <= pix_q;
      fb_we_q      <= s1_valid_q;
      if (s1_valid_q) begin
        fb_addr_q <= s1_pix_q;
        fb_data_q <= rom_data[2:0];
      end
      swap_req_q   <= (state_d == StSwapWait);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign rom_addr  = rom_addr_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign fb_bank   = fb_bank_q;
  assign swap_req  = swap_req_q;
  assign frame_idx = frame_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gif_frame_player.sv
// Directed-sequence bench for gif_frame_player with a randomized ROM image and random ack timing,
// checked against a frame/bank bookkeeping model kept in the bench.
module tb_gif_frame_player;

  localparam int unsigned FW = 32;
  localparam int unsigned FH = 32;
  localparam int unsigned NF = 3;
  localparam int unsigned FT = 4;
  localparam int unsigned PW = 10;
  localparam int unsigned N  = FW * FH;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [15:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          fb_we;
  logic [PW-1:0] fb_addr;
  logic [2:0]    fb_data;
  logic          fb_bank;
  logic          swap_req;
  logic          swap_ack;
  logic [5:0]    frame_idx;
  logic          busy;

  gif_frame_player #(
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .NUM_FRAMES (NF),
    .FRAME_TICKS(FT),
    .PIX_W      (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_bank  (fb_bank),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .frame_idx(frame_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of read latency.
  logic [7:0] rom_mem [65536];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   cur_frame = 0;
  logic cur_bank = 1'b0;
  int   model_frame = 0;
  logic model_bank = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Advance one clock and audit any framebuffer write against the expected stream.
  task automatic tick();
    @(posedge clk);
    #1;
    if (fb_we === 1'b1) begin
      check("wr_addr", 32'(fb_addr), 32'(wr_cnt));
      check("wr_data", 32'(fb_data), 32'(rom_mem[16'(cur_frame * N + wr_cnt)][2:0]));
      check("wr_bank", 32'(fb_bank), 32'(cur_bank));
      wr_cnt++;
    end
  endtask

  // Entered while sampling COPY cycle 0; returns while sampling the first swap_req cycle.
  task automatic copy_frame(input int f, input int drop_at);
    wr_cnt    = 0;
    cur_frame = f;
    cur_bank  = model_bank;
    check("copy_idx", 32'(frame_idx), 32'(f));
    for (int k = 0; k < N; k++) begin
      check("rom_addr", 32'(rom_addr), 32'(f * N + k));
      check("copy_busy", 32'(busy), 32'd1);
      if (k == 1) check("we_lat1", 32'(fb_we), 32'd0);
      if (k == 2) check("we_lat2", 32'({fb_we, fb_addr}), 32'({1'b1, 10'd0}));
      if (k == drop_at) enable = 1'b0;
      swap_ack = 1'($urandom_range(0, 1));
      tick();
    end
    swap_ack = 1'b0;
    tick();
    check("swap_early", 32'(swap_req), 32'd0);
    tick();
    check("swap_req", 32'(swap_req), 32'd1);
    check("wr_count", 32'(wr_cnt), 32'(N));
    check("we_after", 32'(fb_we), 32'd0);
  endtask

  // Hold off the ack for 'delay' cycles, ack, then check the hold length and frame advance.
  task automatic swap_and_hold(input int delay, input bit cont);
    for (int i = 0; i < delay; i++) begin
      check("swap_hold", 32'(swap_req), 32'd1);
      check("wait_no_we", 32'(fb_we), 32'd0);
      tick();
    end
    check("swap_pre", 32'(swap_req), 32'd1);
    swap_ack = 1'b1;
    tick();
    swap_ack   = 1'b0;
    model_bank = ~model_bank;
    check("swap_drop", 32'(swap_req), 32'd0);
    check("bank_toggle", 32'(fb_bank), 32'(model_bank));
    for (int i = 1; i < FT; i++) begin
      check("hold_idx", 32'(frame_idx), 32'(model_frame));
      check("hold_busy", 32'(busy), 32'd1);
      swap_ack = 1'($urandom_range(0, 1));
      tick();
    end
    swap_ack = 1'b0;
    tick();
    model_frame = (model_frame + 1) % NF;
    check("idx_adv", 32'(frame_idx), 32'(model_frame));
    check("busy_after", 32'(busy), 32'(cont));
    if (cont) check("next_base", 32'(rom_addr), 32'(model_frame * N));
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom_mem[a] = 8'($urandom);
    for (int a = 0; a < N; a++) rom_mem[a] = 8'(a);
    rst      = 1'b1;
    enable   = 1'b0;
    swap_ack = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_bank", 32'(fb_bank), 32'd0);
    check("rst_swap", 32'(swap_req), 32'd0);
    check("rst_idx", 32'(frame_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_addr", 32'(rom_addr), 32'd0);
      check("idle_busy0", 32'(busy), 32'd0);
    end

    // First frame, with the ack held off for 50 cycles.
    enable = 1'b1;
    tick();
    copy_frame(model_frame, -1);
    swap_and_hold(50, 1'b1);

    // Continuous play through the frame-index wrap.
    for (int i = 0; i < 3; i++) begin
      copy_frame(model_frame, -1);
      swap_and_hold(int'($urandom_range(0, 40)), 1'b1);
    end

    // Enable dropped mid-copy: frame finishes, then idles.
    copy_frame(model_frame, int'($urandom_range(10, 1000)));
    swap_and_hold(int'($urandom_range(0, 20)), 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_idx", 32'(frame_idx), 32'(model_frame));
      check("stop_swap", 32'(swap_req), 32'd0);
      tick();
    end

    // Reset in the middle of a copy.
    enable = 1'b1;
    tick();
    wr_cnt    = 0;
    cur_frame = model_frame;
    cur_bank  = model_bank;
    for (int k = 0; k < 500; k++) begin
      check("pre_rst_addr", 32'(rom_addr), 32'(model_frame * N + k));
      tick();
    end
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_we", 32'(fb_we), 32'd0);
    check("mid_rst_idx", 32'(frame_idx), 32'd0);
    check("mid_rst_bank", 32'(fb_bank), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_swap", 32'(swap_req), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    model_frame = 0;
    model_bank  = 1'b0;
    wr_cnt      = 0;
    cur_frame   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_we", 32'(fb_we), 32'd0);
    end

    // Restart from frame 0 and stop after it.
    enable = 1'b1;
    tick();
    copy_frame(model_frame, 0);
    swap_and_hold(int'($urandom_range(0, 10)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gif_frame_player.md
Name: gif_frame_player

Overview:
Playback sequencer directly downstream of the GIF frame ROM. It steps through stored frames at a programmable rate and streams each 32x32 frame out of the ROM, honouring the ROM's 1-cycle read latency. Each frame is written into the back bank of the HUB75 double-buffered framebuffer. It then requests a bank swap from the display scanner and holds the frame for a fixed number of clocks.

Parameters:
FRAME_W, 32, pixels per row
FRAME_H, 32, rows per frame
NUM_FRAMES, 60, frames stored in ROM; NUM_FRAMES*FRAME_W*FRAME_H <= 65536
FRAME_TICKS, 5_000_000, clocks a frame is held after swap (>=1)
PIX_W, 10, log2(FRAME_W*FRAME_H)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = play; 0 = stop after current frame's hold
rom_addr  out  16  ROM address; frame_idx*FRAME_W*FRAME_H + y*FRAME_W + x
rom_data  in  8  ROM data; valid 1 cycle after rom_addr; bits[2:0] = R,G,B
fb_we  out  1  framebuffer write strobe
fb_addr  out  PIX_W  framebuffer pixel address (y*FRAME_W + x)
fb_data  out  3  pixel {R,G,B}
fb_bank  out  1  bank being written; display reads ~fb_bank
swap_req  out  1  frame complete, request bank swap
swap_ack  in  1  display accepted swap (1-cycle pulse or level)
frame_idx  out  6  frame currently loaded/being loaded
busy  out  1  1 in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered. They are all 0 on reset: rom_addr, fb_we, fb_addr, fb_data, fb_bank, swap_req, frame_idx, busy.
- Reset also clears the internal frame_base register, the pixel counter, the hold counter and both pipeline valid bits. State goes to IDLE.
- Reset mid-operation aborts immediately. No write strobe is issued in the cycle after reset.
- frame_base is kept as a register, incremented by FRAME_W*FRAME_H per frame. No multiplier is used.

States:
- IDLE: busy=0. When enable=1, go to COPY next cycle with pix=0.
- COPY: cycle k of COPY (k=0..N-1, N=FRAME_W*FRAME_H) presents rom_addr = frame_base+k.
  - Stage 1 captures pix k; stage 2 latches rom_data[2:0] and k.
  - fb_we=1, fb_addr=k, fb_data=rom_data[2:0] appear in cycle k+2.
  - After the cycle presenting k=N-1, go to FLUSH.
  - enable is ignored during COPY.
- FLUSH: 2 cycles draining the pipeline. The last write (addr N-1) occurs in COPY-relative cycle N+1. Then go to SWAP_WAIT.
- SWAP_WAIT: swap_req=1 from COPY-relative cycle N+2.
  - Held until swap_ack is sampled high.
  - On that edge: swap_req->0, fb_bank toggles, hold counter loads FRAME_TICKS-1, go to HOLD.
  - swap_ack outside SWAP_WAIT is ignored.
- HOLD: counter decrements each cycle. When counter==0:
  - frame_idx advances; NUM_FRAMES-1 wraps to 0.
  - frame_base advances by N; it wraps to 0 together with frame_idx.
  - If enable=1 go to COPY, else go to IDLE.
  - The next frame is therefore loaded while the display shows the just-swapped frame.
- Write ordering: writes in one frame are strictly sequential, addr 0..N-1, exactly N strobes. fb_bank is constant during a frame's writes.
- Timing: COPY entry to swap_req is N+2 cycles. Swap_ack edge to next COPY entry is FRAME_TICKS cycles.
- Widths: pixel counter is PIX_W bits; rom_addr is the 16-bit sum, with no overflow given the parameter constraint.

Test Plan:
- Reset then idle: rst for 3 cycles, enable=0 -> all outputs 0, busy=0, rom_addr stays 0 indefinitely.
- First frame latency: ROM model returns addr[2:0], enable=1.
  - rom_addr 0..1023 on consecutive cycles.
  - First fb_we exactly 2 cycles after rom_addr=0, with fb_addr=0, fb_data=0.
  - Write with fb_addr=5 has fb_data=5.
  - Exactly 1024 strobes at fb_bank=0; swap_req rises cycle 1026.
- Delayed ack: hold swap_ack=0 for 50 cycles -> swap_req stays 1 with no writes. Ack -> next cycle swap_req=0 and fb_bank=1.
- Frame advance and wrap: FRAME_TICKS=4, NUM_FRAMES=3, enable=1.
  - Second frame's rom_addr starts at 1024, third at 2048.
  - Fourth frame: frame_idx=0, rom_addr=0, fb_bank back to 0 after 2 swaps.
  - 4 cycles measured from ack edge to first new rom_addr.
- Enable drop: deassert enable mid-COPY -> frame completes all 1024 writes, swap and hold. Then IDLE with busy=0 and frame_idx incremented.
- Reset mid-copy: rst at COPY cycle 500 -> next cycle fb_we=0, frame_idx=0, fb_bank=0, IDLE. Re-enable restarts at rom_addr=0.
